compress_stream_unpacker: RTL and testbench

- Decode-side front end for the packed compressed stream: accepts fixed-width words (MSB-first bit packing, sop/eop framed, last word padded with 1s) and presents a bit-aligned peek window to a downstream Huffman decoder.
- The decoder consumes a variable number of bits per cycle.
- Tracks which row channel the current bits belong to, advancing round-robin on each decoder block_done.
- Detects frame end as the last channel's block_done after eop, then discards the padding.

---
 rtl/compress_stream_unpacker.sv | 150 +++++++++++++++
 tb/tb_compress_stream_unpacker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_stream_unpacker.sv
// Bit-aligned unpacker for the packed compressed stream: MSB-first bit buffer, channel tracking, frame end.
// Optional protocol checker enabled by defining COMPRESS_UNPACK_CHECK_EN; otherwise err is tied low.
module compress_stream_unpacker #(
  parameter int WORD_W = 32,
  parameter int PEEK_W = 16,
  parameter int ROW    = 3,
  localparam int BUF_W = 2 * WORD_W,
  localparam int CNT_W = $clog2(BUF_W + 1),
  localparam int LEN_W = $clog2(PEEK_W + 1),
  localparam int CH_W  = $clog2(ROW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              peek_valid,
  output logic [PEEK_W-1:0] peek_data,
  output logic [CNT_W-1:0]  peek_bits,
  input  logic              consume_en,
  input  logic [LEN_W-1:0]  consume_len,
  input  logic              block_done,
  output logic [CH_W-1:0]   channel,
  output logic              frame_sop,
  output logic              frame_end,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CH_W-1:0]    channel_q, channel_d;
  logic               sop_arm_q, sop_arm_d;
  logic               frame_end_q, frame_end_d;

  logic               accept, load, honour, last_ch;
  logic [CNT_W-1:0]   len_ext;
  logic [BUF_W-1:0]   word_ext;
  logic [PEEK_W-1:0]  fill;

  // Buffer is MSB-aligned: earliest bit at BUF_W-1, bits below count are kept zero.
  assign len_ext  = CNT_W'(consume_len);
  assign word_ext = {in_data, {(BUF_W-WORD_W){1'b0}}};
  assign last_ch  = (channel_q == CH_W'(ROW - 1));

  assign in_ready   = (state_q != S_DRAIN) && (count_q <= CNT_W'(BUF_W - WORD_W));
  assign peek_valid = ((state_q == S_RUN) && (count_q >= CNT_W'(PEEK_W))) ||
                      ((state_q == S_DRAIN) && (count_q != '0));
  assign fill       = {PEEK_W{1'b1}} >> count_q;
  assign peek_data  = (count_q == '0) ? '0 : (buf_q[BUF_W-1 -: PEEK_W] | fill);
  assign peek_bits  = count_q;
  assign channel    = channel_q;
  assign frame_sop  = peek_valid && sop_arm_q;
  assign frame_end  = frame_end_q;

  assign accept = in_valid && in_ready;
  assign honour = consume_en && peek_valid && (len_ext <= count_q);
  assign load   = accept && ((state_q != S_IDLE) || in_sop);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    channel_d   = channel_q;
    sop_arm_d   = sop_arm_q;
    frame_end_d = 1'b0;

    if (honour) begin
      buf_d   = buf_q << consume_len;
      count_d = count_q - len_ext;
      if (consume_len != '0) sop_arm_d = 1'b0;
    end

    // Append lands directly behind the bits that survive this cycle's consume.
    if (load) begin
      buf_d   = buf_d | (word_ext >> count_d);
      count_d = count_d + CNT_W'(WORD_W);
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          channel_d = '0;
          sop_arm_d = 1'b1;
          state_d   = in_eop ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && in_eop) state_d = S_DRAIN;
      end
      default: ;
    endcase

    if (block_done && (state_q != S_IDLE)) begin
      if ((state_q == S_DRAIN) && last_ch) begin
        frame_end_d = 1'b1;
        count_d     = '0;
        buf_d       = '0;
        channel_d   = '0;
        sop_arm_d   = 1'b0;
        state_d     = S_IDLE;
      end else begin
        channel_d = last_ch ? '0 : channel_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      count_q     <= '0;
      channel_q   <= '0;
      sop_arm_q   <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      channel_q   <= channel_d;
      sop_arm_q   <= sop_arm_d;
      frame_end_q <= frame_end_d;
    end
  end

`ifdef COMPRESS_UNPACK_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (consume_en && ((len_ext > count_q) || (consume_len == '0))) err_d = 1'b1;
    if (accept && in_sop && (state_q != S_IDLE))                    err_d = 1'b1;
    if (block_done && (state_q == S_IDLE))                          err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_compress_stream_unpacker.sv
// Testbench for compress_stream_unpacker: directed scenarios plus randomized traffic
// checked against a bit-queue reference model.
module tb_compress_stream_unpacker;
  localparam int WORD_W = 32;
  localparam int PEEK_W = 16;
  localparam int ROW    = 3;
  localparam int BUF_W  = 2 * WORD_W;
  localparam int CNT_W  = $clog2(BUF_W + 1);
  localparam int LEN_W  = $clog2(PEEK_W + 1);
  localparam int CH_W   = $clog2(ROW);
`ifdef COMPRESS_UNPACK_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid, in_ready, in_sop, in_eop;
  logic [WORD_W-1:0] in_data;
  logic              peek_valid;
  logic [PEEK_W-1:0] peek_data;
  logic [CNT_W-1:0]  peek_bits;
  logic              consume_en;
  logic [LEN_W-1:0]  consume_len;
  logic              block_done;
  logic [CH_W-1:0]   channel;
  logic              frame_sop, frame_end, err;

  always #5 clk = ~clk;

  compress_stream_unpacker #(.WORD_W(WORD_W), .PEEK_W(PEEK_W), .ROW(ROW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .peek_valid(peek_valid), .peek_data(peek_data), .peek_bits(peek_bits),
    .consume_en(consume_en), .consume_len(consume_len), .block_done(block_done),
    .channel(channel), .frame_sop(frame_sop), .frame_end(frame_end), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stream bits as a queue, mode 0=idle 1=run 2=drain.
  int m_state;
  bit m_q[$];
  int m_ch;
  bit m_arm, m_fe, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return (m_state != 2) && (m_q.size() <= BUF_W - WORD_W);
  endfunction

  function automatic bit exp_pv();
    return ((m_state == 1) && (m_q.size() >= PEEK_W)) || ((m_state == 2) && (m_q.size() > 0));
  endfunction

  function automatic logic [PEEK_W-1:0] exp_peek();
    logic [PEEK_W-1:0] v;
    for (int i = 0; i < PEEK_W; i++) v[PEEK_W-1-i] = (i < m_q.size()) ? m_q[i] : 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_q.delete();
    m_ch  = 0;
    m_arm = 0;
    m_fe  = 0;
    m_err = 0;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_sop      = 1'b0;
    in_eop      = 1'b0;
    in_data     = '0;
    consume_en  = 1'b0;
    consume_len = '0;
    block_done  = 1'b0;
  endtask

  task automatic compare_all();
    check("in_ready",   32'(in_ready),   32'(exp_ready()));
    check("peek_valid", 32'(peek_valid), 32'(exp_pv()));
    if (exp_pv()) check("peek_data", 32'(peek_data), 32'(exp_peek()));
    check("peek_bits",  32'(peek_bits),  32'(m_q.size()));
    check("channel",    32'(channel),    32'(m_ch));
    check("frame_sop",  32'(frame_sop),  32'(exp_pv() && m_arm));
    check("frame_end",  32'(frame_end),  32'(m_fe));
    check("err",        32'(err),        32'(m_err));
  endtask

  task automatic model_step();
    int cnt = m_q.size();
    int old = m_state;
    bit pv  = exp_pv();
    bit acc = in_valid && exp_ready();
    int len = int'(consume_len);
    if (ERR_EN) begin
      if (consume_en && (len > cnt || len == 0)) m_err = 1;
      if (acc && in_sop && old != 0) m_err = 1;
      if (block_done && old == 0) m_err = 1;
    end
    if (consume_en && pv && len <= cnt) begin
      repeat (len) void'(m_q.pop_front());
      if (len > 0) m_arm = 0;
    end
    if (acc && (old != 0 || in_sop))
      for (int i = WORD_W - 1; i >= 0; i--) m_q.push_back(in_data[i]);
    if (acc && old == 0 && in_sop) begin
      m_ch = 0;
      m_arm = 1;
      m_state = in_eop ? 2 : 1;
    end else if (acc && old == 1 && in_eop) begin
      m_state = 2;
    end
    m_fe = 0;
    if (block_done && old != 0) begin
      if (old == 2 && m_ch == ROW - 1) begin
        m_fe = 1;
        m_q.delete();
        m_ch = 0;
        m_arm = 0;
        m_state = 0;
      end else begin
        m_ch = (m_ch + 1) % ROW;
      end
    end
  endtask

  task automatic cycle();
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit sop, input bit eop);
    idle_in();
    in_valid = 1'b1; in_data = w; in_sop = sop; in_eop = eop;
    cycle();
    idle_in();
  endtask

  task automatic consume(input int n);
    idle_in();
    consume_en = 1'b1; consume_len = LEN_W'(n);
    cycle();
    idle_in();
  endtask

  // Push the frame to completion: eop word while running, block_done while draining.
  task automatic finish_frame();
    int guard = 0;
    while (m_state != 0 && guard < 64) begin
      idle_in();
      if (m_state == 1) begin
        in_valid = 1'b1; in_eop = 1'b1; in_data = $urandom;
        consume_en = exp_pv(); consume_len = LEN_W'(16);
      end else begin
        block_done = 1'b1;
      end
      cycle();
      guard++;
    end
    idle_in();
    check("frame_closed_ready", 32'(in_ready), 32'd1);
    check("frame_closed_pv",    32'(peek_valid), 32'd0);
  endtask

  initial begin
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_peek_data", 32'(peek_data), 32'd0);
    rst_n = 1'b1;
    cycle();

    // single-word frame
    send_word(32'hA5F0FFFF, 1, 1);
    check("t1_peek_valid", 32'(peek_valid), 32'd1);
    check("t1_peek", 32'(peek_data), 32'h0000A5F0);
    check("t1_frame_sop", 32'(frame_sop), 32'd1);
    check("t1_bits", 32'(peek_bits), 32'd32);
    consume(16);
    check("t1_tail", 32'(peek_data), 32'h0000FFFF);
    check("t1_sop_cleared", 32'(frame_sop), 32'd0);
    block_done = 1'b1;
    cycle();
    check("t1_ch1", 32'(channel), 32'd1);
    cycle();
    check("t1_ch2", 32'(channel), 32'd2);
    cycle();
    idle_in();
    check("t1_frame_end", 32'(frame_end), 32'd1);
    check("t1_pv_off", 32'(peek_valid), 32'd0);
    check("t1_ready", 32'(in_ready), 32'd1);
    cycle();

    // word without sop in idle is dropped
    send_word(32'hDEADBEEF, 0, 0);
    check("nosop_pv", 32'(peek_valid), 32'd0);
    check("nosop_bits", 32'(peek_bits), 32'd0);

    // backpressure
    send_word(32'h12345678, 1, 0);
    send_word(32'h9ABCDEF0, 0, 0);
    check("bp_bits64", 32'(peek_bits), 32'd64);
    check("bp_ready64", 32'(in_ready), 32'd0);
    check("bp_peek64", 32'(peek_data), 32'h1234);
    consume(8);
    check("bp_bits56", 32'(peek_bits), 32'd56);
    check("bp_ready56", 32'(in_ready), 32'd0);
    check("bp_peek56", 32'(peek_data), 32'h3456);
    consume(16);
    check("bp_bits40", 32'(peek_bits), 32'd40);
    check("bp_ready40", 32'(in_ready), 32'd0);
    check("bp_peek40", 32'(peek_data), 32'h789A);
    consume(8);
    check("bp_bits32", 32'(peek_bits), 32'd32);
    check("bp_ready32", 32'(in_ready), 32'd1);
    check("bp_peek32", 32'(peek_data), 32'h9ABC);
    finish_frame();

    // simultaneous load and consume
    send_word($urandom, 1, 0);
    consume(12);
    check("lc_bits20", 32'(peek_bits), 32'd20);
    in_valid = 1'b1; in_data = $urandom; consume_en = 1'b1; consume_len = LEN_W'(5);
    cycle();
    idle_in();
    check("lc_bits47", 32'(peek_bits), 32'd47);
    consume(16);
    consume(16);
    finish_frame();

    // drain tail padded with ones
    send_word(32'hABCDE2CE, 1, 1);
    consume(16);
    consume(6);
    check("tail_peek", 32'(peek_data), 32'h0000B3BF);
    check("tail_pv", 32'(peek_valid), 32'd1);
    check("tail_bits", 32'(peek_bits), 32'd10);
    finish_frame();

    // over-long consume is ignored
    send_word($urandom, 1, 0);
    consume(16);
    check("len17_pre_bits", 32'(peek_bits), 32'd16);
    consume(17);
    check("len17_bits", 32'(peek_bits), 32'd16);
    check("len17_err", 32'(err), 32'(ERR_EN));
    finish_frame();

    // reset clears the sticky state
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = $urandom;
      if (m_state == 0) begin
        in_sop = ($urandom_range(0, 99) < 70);
        in_eop = ($urandom_range(0, 99) < 25);
        block_done = ($urandom_range(0, 99) < 3);
      end else begin
        in_sop = ($urandom_range(0, 99) < 3);
        in_eop = ($urandom_range(0, 99) < 15);
        block_done = ($urandom_range(0, 99) < 10);
      end
      consume_en  = ($urandom_range(0, 99) < 60);
      consume_len = LEN_W'($urandom_range(0, 17));
      cycle();
    end
    idle_in();
    compare_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
